memory_responder: RTL and testbench

- Memory-side responder for the memory accessor's MEM_* interface: word-addressed single-port RAM model with configurable wait states.
- Accepts one address/data request per valid/ready handshake and returns exactly one 32-bit response word per request.
- Every request, read (REF) or write (SET), returns the word's previous contents. SET is therefore read-before-write, i.e. a swap.
- Sits between memory_accessor and the simulation/FPGA top; one transaction outstanding at a time.

---
 rtl/memory_responder.sv | 129 ++++++++++++
 tb/tb_memory_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed RAM responder with a swap on every request: each request returns the word's contents from before the request.
// Latency: the response is valid LATENCY+1 edges after accept; one request is outstanding at a time.
// Backpressure: READY stays low until the response handshakes. MEM_RESPONDER_BOUNDS_CHECK_EN enables out-of-range rejection.
module memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_SEND_ADDR_VALID,
    input  logic [31:0] MEM_SEND_ADDR,
    input  logic        MEM_SEND_DATA_VALID,
    input  logic [31:0] MEM_SEND_DATA,
    output logic        MEM_SEND_READY,
    output logic        MEM_RECEIVE_VALID,
    output logic [31:0] MEM_RECEIVE_DATA,
    input  logic        MEM_RECEIVE_READY
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LOAD = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic                  r_send_ready;
    logic                  w_send_ready_nxt;
    logic                  r_recv_valid;
    logic                  w_recv_valid_nxt;
    logic [31:0]           r_recv_data;
    logic [31:0]           r_mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oob;
    logic                  w_accept;
    logic                  w_wr;

    assign w_idx    = MEM_SEND_ADDR[ADDR_WIDTH-1:0];
    assign w_oob    = BOUNDS_EN & (|MEM_SEND_ADDR[31:ADDR_WIDTH]);
    assign w_accept = RST & MEM_SEND_ADDR_VALID & r_send_ready;
    assign w_wr     = w_accept & MEM_SEND_DATA_VALID & ~w_oob;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_send_ready <= 1'b0;
            r_recv_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_send_ready <= w_send_ready_nxt;
            r_recv_valid <= w_recv_valid_nxt;
        end
    end

    // RESP spends its first cycle raising VALID, which sets the LATENCY+1 edge response timing.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_send_ready_nxt = r_send_ready;
        w_recv_valid_nxt = r_recv_valid;
        case (r_state)
            IDLE: begin
                w_send_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_send_ready_nxt = 1'b0;
                    if (LATENCY == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            RESP: begin
                if (!r_recv_valid) begin
                    w_recv_valid_nxt = 1'b1;
                end else if (MEM_RECEIVE_READY) begin
                    w_recv_valid_nxt = 1'b0;
                    w_send_ready_nxt = 1'b1;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_recv_data <= 32'd0;
        end else if (w_accept) begin
            r_recv_data <= w_oob ? 32'hDEAD_BEEF : r_mem[w_idx];
        end
    end

    // The RAM has no reset, so a write committed at its accept edge survives a later reset.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[w_idx] <= MEM_SEND_DATA;
        end
    end

    assign MEM_SEND_READY    = r_send_ready;
    assign MEM_RECEIVE_VALID = r_recv_valid;
    assign MEM_RECEIVE_DATA  = r_recv_data;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: a transaction-level RAM model checked every cycle, plus directed literal expectations.
module tb_memory_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_SEND_ADDR_VALID;
    logic [31:0] MEM_SEND_ADDR;
    logic        MEM_SEND_DATA_VALID;
    logic [31:0] MEM_SEND_DATA;
    logic        MEM_SEND_READY;
    logic        MEM_RECEIVE_VALID;
    logic [31:0] MEM_RECEIVE_DATA;
    logic        MEM_RECEIVE_READY;

    logic        z_av, z_dv, z_ready, z_valid, z_rr;
    logic [31:0] z_addr, z_data, z_rdata;

    memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
        .MEM_SEND_ADDR       (MEM_SEND_ADDR),
        .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
        .MEM_SEND_DATA       (MEM_SEND_DATA),
        .MEM_SEND_READY      (MEM_SEND_READY),
        .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
        .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY   (MEM_RECEIVE_READY)
    );

    memory_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut_lat0 (
        .CLK                 (CLK),
        .RST                 (RST),
        .MEM_SEND_ADDR_VALID (z_av),
        .MEM_SEND_ADDR       (z_addr),
        .MEM_SEND_DATA_VALID (z_dv),
        .MEM_SEND_DATA       (z_data),
        .MEM_SEND_READY      (z_ready),
        .MEM_RECEIVE_VALID   (z_valid),
        .MEM_RECEIVE_DATA    (z_rdata),
        .MEM_RECEIVE_READY   (z_rr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, required %08h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        chk(nm, {31'd0, got}, {31'd0, exp});
    endtask

    // Model: RAM contents as an array, plus one outstanding request and the edge at which its response must appear.
    logic [31:0] m_mem   [1024];
    bit          m_known [1024];
    bit          m_init  = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_dknown = 1'b0;
    logic [31:0] m_data  = 32'd0;
    int          m_resp_edge = 0;

    always @(negedge CLK) begin : model
        bit v;
        bit oob;
        int idx;
        v = m_busy && (cyc >= m_resp_edge);
        if (m_init) begin
            chk1("send_ready", MEM_SEND_READY, m_ready);
            chk1("recv_valid", MEM_RECEIVE_VALID, v);
            if (m_dknown) chk("recv_data", MEM_RECEIVE_DATA, m_data);
        end
        if (!RST) begin
            m_init   = 1'b1;
            m_busy   = 1'b0;
            m_ready  = 1'b0;
            m_data   = 32'd0;
            m_dknown = 1'b1;
        end else if (m_init) begin
            if (!m_busy) begin
                if (m_ready && MEM_SEND_ADDR_VALID) begin
                    idx = int'(MEM_SEND_ADDR[AW-1:0]);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                    oob = |MEM_SEND_ADDR[31:AW];
`else
                    oob = 1'b0;
`endif
                    m_dknown = oob || m_known[idx];
                    m_data   = oob ? 32'hDEAD_BEEF : m_mem[idx];
                    if (MEM_SEND_DATA_VALID && !oob) begin
                        m_mem[idx]   = MEM_SEND_DATA;
                        m_known[idx] = 1'b1;
                    end
                    m_busy      = 1'b1;
                    m_ready     = 1'b0;
                    m_resp_edge = cyc + LAT + 2;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (v && MEM_RECEIVE_READY) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input int stall, output logic [31:0] resp, output int lat);
        int t;
        int held;
        @(posedge CLK); #1;
        MEM_SEND_ADDR_VALID = 1'b1;
        MEM_SEND_ADDR       = addr;
        MEM_SEND_DATA_VALID = wr;
        MEM_SEND_DATA       = data;
        MEM_RECEIVE_READY   = 1'b0;
        t = 0;
        while (!MEM_SEND_READY && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        if (!MEM_SEND_READY) begin
            n_chk++;
            $display("FAIL accept_timeout: send_ready low for %0d cycles, required high", t);
        end
        @(posedge CLK); #1;
        MEM_SEND_ADDR_VALID = 1'b0;
        MEM_SEND_ADDR       = $urandom;
        MEM_SEND_DATA_VALID = 1'($urandom_range(0, 1));
        MEM_SEND_DATA       = $urandom;
        lat = 0;
        while (!MEM_RECEIVE_VALID && lat < 300) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!MEM_RECEIVE_VALID) begin
            n_chk++;
            $display("FAIL resp_timeout: recv_valid low for %0d cycles, required high", lat);
        end
        resp = MEM_RECEIVE_DATA;
        held = 0;
        // A stray write offered while busy must never be accepted.
        for (int i = 0; i < stall; i++) begin
            MEM_SEND_ADDR_VALID = 1'b1;
            MEM_SEND_ADDR       = {addr[31:1], ~addr[0]};
            MEM_SEND_DATA_VALID = 1'b1;
            MEM_SEND_DATA       = 32'hBAD0_0BAD;
            @(posedge CLK); #1;
            if (MEM_RECEIVE_VALID && !MEM_SEND_READY && MEM_RECEIVE_DATA === resp) held++;
        end
        if (stall > 0) chk("bp_held_cycles", 32'(held), 32'(stall));
        MEM_SEND_ADDR_VALID = 1'b0;
        MEM_RECEIVE_READY   = 1'b1;
        @(posedge CLK); #1;
        MEM_RECEIVE_READY = 1'b0;
        chk1("hs_valid_low", MEM_RECEIVE_VALID, 1'b0);
        chk1("hs_ready_high", MEM_SEND_READY, 1'b1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] r;
        int          l;
        logic [31:0] a;
        RST                 = 1'b0;
        MEM_SEND_ADDR_VALID = 1'b1;
        MEM_SEND_ADDR       = 32'd5;
        MEM_SEND_DATA_VALID = 1'b1;
        MEM_SEND_DATA       = 32'hFFFF_0000;
        MEM_RECEIVE_READY   = 1'b0;
        z_av = 1'b0; z_dv = 1'b0; z_addr = 32'd0; z_data = 32'd0; z_rr = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk1("rst_send_ready", MEM_SEND_READY, 1'b0);
            chk1("rst_recv_valid", MEM_RECEIVE_VALID, 1'b0);
            chk("rst_recv_data", MEM_RECEIVE_DATA, 32'd0);
        end
        RST                 = 1'b1;
        MEM_SEND_ADDR_VALID = 1'b0;
        @(posedge CLK); #1;
        chk1("release_ready", MEM_SEND_READY, 1'b1);

        do_req(32'd5, 1'b1, 32'h1234_5678, 0, r, l);
        do_req(32'd5, 1'b0, 32'h0, 0, r, l);
        chk("ref5", r, 32'h1234_5678);
        chk("latency_edges", 32'(l), 32'd3);

        do_req(32'd7, 1'b1, 32'hAAAA_0000, 0, r, l);
        do_req(32'd7, 1'b1, 32'h5555_FFFF, 0, r, l);
        chk("swap7", r, 32'hAAAA_0000);
        do_req(32'd7, 1'b0, 32'h0, 0, r, l);
        chk("ref7", r, 32'h5555_FFFF);

        do_req(32'd6, 1'b1, 32'h0000_0006, 0, r, l);
        do_req(32'd7, 1'b0, 32'h0, 10, r, l);
        chk("bp_ref7", r, 32'h5555_FFFF);
        do_req(32'd6, 1'b0, 32'h0, 0, r, l);
        chk("bp_no_stray_write", r, 32'h0000_0006);

        do_req(32'd3, 1'b1, 32'h3333_3333, 0, r, l);
        do_req(32'h0000_0403, 1'b1, 32'hCAFE_F00D, 0, r, l);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        chk("oob_set_resp", r, 32'hDEAD_BEEF);
        do_req(32'd3, 1'b0, 32'h0, 0, r, l);
        chk("oob_ref3", r, 32'h3333_3333);
`else
        chk("alias_set_resp", r, 32'h3333_3333);
        do_req(32'd3, 1'b0, 32'h0, 0, r, l);
        chk("alias_ref3", r, 32'hCAFE_F00D);
`endif

        @(posedge CLK); #1;
        MEM_SEND_ADDR_VALID = 1'b1;
        MEM_SEND_ADDR       = 32'd11;
        MEM_SEND_DATA_VALID = 1'b1;
        MEM_SEND_DATA       = 32'h1111_1111;
        chk1("midrst_ready", MEM_SEND_READY, 1'b1);
        @(posedge CLK); #1;
        MEM_SEND_ADDR_VALID = 1'b0;
        RST                 = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        chk1("midrst_valid", MEM_RECEIVE_VALID, 1'b0);
        chk1("midrst_ready_low", MEM_SEND_READY, 1'b0);
        do_req(32'd11, 1'b0, 32'h0, 0, r, l);
        chk("midrst_ref11", r, 32'h1111_1111);

        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            z_av = 1'b1; z_dv = (k == 0); z_addr = 32'd2; z_data = 32'h0BAD_F00D;
            chk1("z_ready_idle", z_ready, 1'b1);
            @(posedge CLK); #1;
            z_av = 1'b0;
            chk1("z_valid_at_accept", z_valid, 1'b0);
            @(posedge CLK); #1;
            chk1("z_valid_lat0", z_valid, 1'b1);
            if (k == 1) chk("z_ref2", z_rdata, 32'h0BAD_F00D);
            z_rr = 1'b1;
            @(posedge CLK); #1;
            z_rr = 1'b0;
            chk1("z_valid_after_hs", z_valid, 1'b0);
            chk1("z_ready_after_hs", z_ready, 1'b1);
        end

        for (int i = 0; i < 16; i++) do_req(32'(i), 1'b1, $urandom, 0, r, l);
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            do_req(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)), r, l);
        end

        @(posedge CLK); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
